// File: rtl/serializer_multilane.sv
// Parallel-to-serial converter with a hold register so that consecutive words stream
// out with no idle beat. Each word is sent over LANES lanes, N = WIDTH/LANES beats per word.
module serializer_multilane #(
  parameter int WIDTH     = 16,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b1,
  localparam int N        = WIDTH / LANES,
  localparam int CW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] PAR_IN,
  input  logic             PAR_VALID,
  output logic             PAR_READY,
  output logic [LANES-1:0] SERIAL_OUT,
  output logic             FRAME,
  output logic             ACTIVE,
  output logic [CW-1:0]    COUNT
);

  // state   | meaning
  // S_IDLE  | nothing to send, outputs held at zero
  // S_SHIFT | shift word on the lanes, r_cnt is the beat index
  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_word, w_word_nxt;
  logic [WIDTH-1:0] r_hold, w_hold_nxt;
  logic             r_hold_valid, w_hold_valid_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [LANES-1:0] r_serial, w_serial_nxt;
  logic             r_frame, w_frame_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_loadable;

  function automatic logic [LANES-1:0] beat_slice(input logic [WIDTH-1:0] word,
                                                  input logic [CW-1:0]    idx);
    logic [WIDTH-1:0] sh;
    if (MSB_FIRST) sh = word >> (WIDTH - (int'(idx) + 1) * LANES);
    else           sh = word >> (int'(idx) * LANES);
    return sh[LANES-1:0];
  endfunction

  assign PAR_READY  = ~r_hold_valid & ~RESET;
  assign w_accept   = PAR_VALID & PAR_READY;
  assign w_last     = (r_cnt == CW'(N - 1));
  assign w_loadable = (r_state == S_IDLE) | w_last;

  always_comb begin
    w_state_nxt      = r_state;
    w_word_nxt       = r_word;
    w_cnt_nxt        = r_cnt;
    w_hold_nxt       = r_hold;
    w_hold_valid_nxt = r_hold_valid;

    if (w_loadable && r_hold_valid) begin
      w_state_nxt      = S_SHIFT;
      w_word_nxt       = r_hold;
      w_cnt_nxt        = '0;
      w_hold_valid_nxt = w_accept;
      if (w_accept) w_hold_nxt = PAR_IN;
    end else if (w_loadable && w_accept) begin
      // hold bypass: an empty hold and a free shift stage take the word directly
      w_state_nxt = S_SHIFT;
      w_word_nxt  = PAR_IN;
      w_cnt_nxt   = '0;
    end else if (w_loadable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
      if (w_accept) begin
        w_hold_nxt       = PAR_IN;
        w_hold_valid_nxt = 1'b1;
      end
    end

    w_serial_nxt = '0;
    w_frame_nxt  = 1'b0;
    if (w_state_nxt == S_SHIFT) begin
      w_serial_nxt = beat_slice(w_word_nxt, w_cnt_nxt);
      w_frame_nxt  = (w_cnt_nxt == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_word       <= '0;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_serial     <= '0;
      r_frame      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_word       <= w_word_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_serial     <= w_serial_nxt;
      r_frame      <= w_frame_nxt;
    end
  end

  assign SERIAL_OUT = r_serial;
  assign FRAME      = r_frame;
  assign ACTIVE     = (r_state == S_SHIFT);
  assign COUNT      = r_cnt;

endmodule

// File: tb/tb_serializer_multilane.sv
// Bench for serializer_multilane: four configurations driven together, checked each cycle
// against a queue-of-beats model, plus literal checks on the worked examples.
module tb_serializer_multilane;

  function automatic int lanes_of(input int k);
    case (k)
      1: return 4;
      3: return 16;
      default: return 1;
    endcase
  endfunction

  function automatic bit msb_of(input int k);
    return (k == 2) ? 1'b0 : 1'b1;
  endfunction

  typedef struct packed {
    logic [15:0] ser;
    logic [3:0]  cnt;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] par_in [4];
  logic [3:0]  par_valid;
  logic [3:0]  ready, frame, active;
  logic [15:0] ser_w [4];
  logic [3:0]  cnt_w [4];

  int n_cmp = 0;
  int n_err = 0;

  beat_t q [4][$];
  beat_t cur [4];
  logic [3:0] cur_v;

  logic [63:0] cap;
  logic [63:0] cc;
  logic [31:0] fm;
  int          lowc;
  int          actc;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g
    localparam int L   = lanes_of(k);
    localparam bit MF  = msb_of(k);
    localparam int NB  = 16 / L;
    localparam int CWK = (NB > 1) ? $clog2(NB) : 1;
    logic [L-1:0]   so;
    logic [CWK-1:0] cnt;
    serializer_multilane #(.WIDTH(16), .LANES(L), .MSB_FIRST(MF)) u_dut (
      .CLK(clk), .RESET(rst), .PAR_IN(par_in[k]), .PAR_VALID(par_valid[k]),
      .PAR_READY(ready[k]), .SERIAL_OUT(so), .FRAME(frame[k]), .ACTIVE(active[k]),
      .COUNT(cnt));
    assign ser_w[k] = 16'(so);
    assign cnt_w[k] = 4'(cnt);
  end

  task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %h, required %h", nm, k, $time, got, exp);
    end
  endtask

  function automatic beat_t mk_beat(input int k, input logic [15:0] w, input int b);
    beat_t       r;
    int          l;
    logic [31:0] m, x;
    l = lanes_of(k);
    m = (32'd1 << l) - 32'd1;
    if (msb_of(k)) x = 32'(w) >> (16 - (b + 1) * l);
    else           x = 32'(w) >> (b * l);
    r.ser = 16'(x & m);
    r.cnt = 4'(b);
    return r;
  endfunction

  // Model: accepted words become N beats in a FIFO; one beat is shown per cycle.
  initial begin
    int   nb;
    logic er, acc, ef;
    for (int k = 0; k < 4; k++) cur[k] = '0;
    cur_v = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        nb = 16 / lanes_of(k);
        ef = cur_v[k] && (cur[k].cnt == 4'd0);
        er = !rst && (q[k].size() <= nb - 1 - int'(cur[k].cnt));
        chk("ser",    k, 64'(ser_w[k]),  64'(cur_v[k] ? cur[k].ser : 16'd0));
        chk("count",  k, 64'(cnt_w[k]),  64'(cur_v[k] ? cur[k].cnt : 4'd0));
        chk("active", k, 64'(active[k]), 64'(cur_v[k]));
        chk("frame",  k, 64'(frame[k]),  64'(ef));
        chk("ready",  k, 64'(ready[k]),  64'(er));
        acc = par_valid[k] && er;
        if (rst) begin
          q[k].delete();
          cur_v[k] = 1'b0;
          cur[k]   = '0;
        end else begin
          if (acc) for (int b = 0; b < nb; b++) q[k].push_back(mk_beat(k, par_in[k], b));
          if (q[k].size() > 0) begin
            cur[k]   = q[k].pop_front();
            cur_v[k] = 1'b1;
          end else begin
            cur[k]   = '0;
            cur_v[k] = 1'b0;
          end
        end
      end
    end
  end

  task automatic send_one(input int k, input logic [15:0] w);
    int t;
    par_in[k]    = w;
    par_valid[k] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!ready[k] && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!ready[k]) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout[%0d]: ready stayed 0, required 1", k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        par_valid[k] = 1'b0;
        par_in[k]    = 16'($urandom);
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1;
      end
      send_one(k, 16'($urandom));
    end
    par_valid[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) par_in[k] = 16'h0;
    par_valid = 4'h0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 0, 64'(ready), 64'h0);
    chk("rst_outs", 0, 64'({active, frame, ser_w[0], cnt_w[0]}), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 0, 64'(ready), 64'hF);
    @(posedge clk);
    #1;

    // single word, one lane, MSB first
    send_one(0, 16'hC5AF);
    par_valid[0] = 1'b0;
    cap = '0; fm = '0; cc = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      cap = {cap[62:0], ser_w[0][0]};
      fm  = {fm[30:0], frame[0]};
      cc  = {cc[59:0], cnt_w[0]};
    end
    chk("t1_bits",  0, cap[15:0], 64'hC5AF);
    chk("t1_frame", 0, 64'(fm[15:0]), 64'h8000);
    chk("t1_count", 0, cc, 64'h0123456789ABCDEF);
    @(negedge clk);
    chk("t1_idle", 0, 64'({active[0], ser_w[0]}), 64'h0);
    @(posedge clk);
    #1;

    // back-to-back with valid held high
    send_one(0, 16'hC5AF);
    cap = '0; fm = '0; lowc = 0;
    fork
      begin
        send_one(0, 16'h0001);
        par_valid[0] = 1'b0;
      end
      for (int i = 0; i < 32; i++) begin
        @(negedge clk);
        cap = {cap[62:0], ser_w[0][0]};
        fm  = {fm[30:0], frame[0]};
        if (!ready[0]) lowc++;
      end
    join
    chk("t2_bits",  0, 64'(cap[31:0]), 64'hC5AF0001);
    chk("t2_frame", 0, 64'(fm), 64'h80008000);
    chk("t2_ready_low", 0, 64'(lowc), 64'd15);
    repeat (2) @(posedge clk);
    #1;

    // four lanes
    send_one(1, 16'hC5AF);
    par_valid[1] = 1'b0;
    cap = '0; cc = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cap = {cap[59:0], ser_w[1][3:0]};
      cc  = {cc[61:0], cnt_w[1][1:0]};
    end
    chk("t3_beats", 1, 64'(cap[15:0]), 64'hC5AF);
    chk("t3_count", 1, 64'(cc[7:0]), 64'h1B);
    repeat (2) @(posedge clk);
    #1;

    // LSB first
    send_one(2, 16'h0001);
    cap = '0;
    fork
      begin
        send_one(2, 16'h8000);
        par_valid[2] = 1'b0;
      end
      for (int i = 0; i < 32; i++) begin
        @(negedge clk);
        cap = {cap[62:0], ser_w[2][0]};
      end
    join
    chk("t4_bits", 2, 64'(cap[31:0]), 64'h80000001);
    repeat (2) @(posedge clk);
    #1;

    // backpressure with three words
    send_one(0, 16'hA1B2);
    cap = '0;
    fork
      begin
        send_one(0, 16'h3C4D);
        send_one(0, 16'h5E6F);
        par_valid[0] = 1'b0;
      end
      for (int i = 0; i < 48; i++) begin
        @(negedge clk);
        cap = {cap[62:0], ser_w[0][0]};
      end
    join
    chk("t5_bits", 0, 64'(cap[47:0]), 64'hA1B23C4D5E6F);
    @(negedge clk);
    chk("t5_done", 0, 64'(active[0]), 64'h0);
    @(posedge clk);
    #1;

    // reset mid-word with a word sitting in hold
    send_one(0, 16'hFFFF);
    send_one(0, 16'h1234);
    par_in[0]    = 16'hBEEF;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_ready_in_rst", 0, 64'(ready[0]), 64'h0);
    chk("t6_beat5", 0, 64'({active[0], cnt_w[0], ser_w[0]}), 64'h1_5_0001);
    @(negedge clk);
    chk("t6_zeroed", 0, 64'({active[0], frame[0], cnt_w[0], ser_w[0]}), 64'h0);
    @(posedge clk);
    #1 par_valid[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ready_rel", 0, 64'(ready[0]), 64'h1);
    @(posedge clk);
    #1;
    send_one(0, 16'hC5AF);
    par_valid[0] = 1'b0;
    cap = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      cap = {cap[62:0], ser_w[0][0]};
    end
    chk("t6_bits", 0, 64'(cap[15:0]), 64'hC5AF);
    repeat (20) @(negedge clk);
    chk("t6_no_ghost", 0, 64'(active[0]), 64'h0);
    @(posedge clk);
    #1;

    // N=1: one word per cycle
    actc = 0; lowc = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_one(3, 16'($urandom));
        par_valid[3] = 1'b0;
      end
      begin
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          if (active[3]) actc++;
          if (frame[3]) lowc++;
        end
      end
    join
    chk("t7_active", 3, 64'(actc), 64'd8);
    chk("t7_frames", 3, 64'(lowc), 64'd8);
    repeat (3) @(posedge clk);
    #1;

    // random traffic on all configurations at once
    fork
      drive_rand(0, 30);
      drive_rand(1, 60);
      drive_rand(2, 30);
      drive_rand(3, 150);
    join
    repeat (40) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serializer_multilane.md
# serializer_multilane

Parametrised parallel-to-serial converter: the next generation of the 16-bit serializer unit cell. It accepts WIDTH-bit words over a valid/ready handshake and double-buffers them, so back-to-back words stream with no gap. Each word is shifted out over LANES parallel serial lanes in a selectable bit order, with a frame marker and beat counter. It sits between the parallel datapath and the lane drivers of the SerDes transmit path.

## Interface
- WIDTH, 16: parallel word width; must be a multiple of LANES.
- LANES, 1: serial lanes driven per cycle; N = WIDTH/LANES beats per word.
- MSB_FIRST, 1: 1 sends high-order bits first; 0 sends low-order bits first.
- CW, max(1, $clog2(N)): COUNT width (derived, not overridden).

Ports:
- CLK  in  1  single clock; everything on posedge.
- RESET  in  1  synchronous, active-high reset.
- PAR_IN  in  WIDTH  parallel word; sampled on an accepting edge.
- PAR_VALID  in  1  PAR_IN holds a word.
- PAR_READY  out  1  block can take a word this cycle.
- SERIAL_OUT  out  LANES  current beat.
- FRAME  out  1  high on beat 0 of every word.
- ACTIVE  out  1  SERIAL_OUT carries word data.
- COUNT  out  CW  beat index 0..N-1 of the current word.

## Operation
- **Storage.**
  - Shift stage: word register, ACTIVE flag and beat counter.
  - Hold stage: word register plus hold_valid.
- **Handshake.**
  - PAR_READY = ~hold_valid & ~RESET.
  - Accept occurs when PAR_VALID & PAR_READY at a rising edge.
- **Beat slice.**
  - MSB_FIRST=1: beat b drives PAR_IN[WIDTH-1-b*LANES -: LANES], with SERIAL_OUT[LANES-1] carrying the higher-order bit.
  - MSB_FIRST=0: beat b drives PAR_IN[b*LANES +: LANES].
- **States.**
  - IDLE: ACTIVE=0.
  - SHIFT: ACTIVE=1, counter advancing.
- **Load condition.** At each edge, the shift stage is loadable if it is in IDLE or COUNT==N-1.
- **Shift-stage update** (evaluated in this priority order):
  1. Loadable and hold_valid: load the hold word, go to SHIFT, COUNT←0, hold_valid←0.
  2. Otherwise, loadable and an accept occurs: load PAR_IN directly, go to SHIFT, COUNT←0 (hold bypass).
  3. Otherwise, loadable: go to IDLE, COUNT←0.
  4. Otherwise (SHIFT, not last beat): COUNT←COUNT+1.
- **Hold-stage update.**
  - An accept not consumed by rule 2 sets hold_valid and captures PAR_IN.
  - Rule 1 and a new accept on the same edge: hold is emptied and refilled on that edge; hold_valid stays 1.
- **Idle outputs.** SERIAL_OUT=0, FRAME=0, COUNT=0.
- **Registered outputs.** SERIAL_OUT, FRAME and COUNT are registered, and FRAME = ACTIVE & (COUNT==0).
- **N=1 (LANES=WIDTH).** Every beat is the last beat; the block sustains one word per cycle.
- **Reset.**
  - Synchronous; overrides all other updates.
  - Clears both stages and discards any word in flight, including mid-word.
  - PAR_VALID is ignored while RESET is high.

## Timing
- **Reset values.** SERIAL_OUT=0, FRAME=0, ACTIVE=0, COUNT=0, PAR_READY=0 while RESET is high. PAR_READY=1 from the first cycle after RESET falls.
- **Latency from IDLE.** A word accepted at edge t shows beat 0 (FRAME=1, COUNT=0) in the cycle after edge t; beat N-1 follows N-1 cycles later.
- **Throughput.** One word per N cycles with no idle beat between words, provided the next word is accepted before or at the last-beat edge of the current word.
- **Backpressure.**
  - While the hold stage is full, PAR_READY=0.
  - PAR_READY rises in the cycle after the hold word moves to the shift stage.
  - The sender must keep PAR_VALID and PAR_IN stable until accepted; a held word is never dropped or duplicated.
- **Reset mid-word.** RESET at edge r zeroes all outputs from the cycle after edge r; no partial word resumes.

## Test plan
- **Single word, LANES=1, MSB_FIRST=1.**
  - Stimulus: one accept of 16'hC5AF from IDLE.
  - Required: SERIAL_OUT over 16 cycles = 1100010110101111.
  - Required: FRAME high only on the first cycle; COUNT runs 0..15; then ACTIVE=0 and SERIAL_OUT=0.
- **Back-to-back, LANES=1.**
  - Stimulus: PAR_VALID held high with 16'hC5AF, then 16'h0001.
  - Required: 32 contiguous bits 1100010110101111 0000000000000001.
  - Required: FRAME at cycles 0 and 16; PAR_READY low while the hold stage is full; no gap.
- **LANES=4, MSB_FIRST=1.**
  - Stimulus: 16'hC5AF.
  - Required: beats 4'hC, 4'h5, 4'hA, 4'hF on consecutive cycles; COUNT 0..3.
- **LSB-first, LANES=1, MSB_FIRST=0.**
  - Stimulus: 16'h0001, then 16'h8000.
  - Required: first bit 1 followed by 15 zeros, then 15 zeros followed by 1.
- **Backpressure.**
  - Stimulus: three words with PAR_VALID always high; each word changes only after its accept.
  - Required: exactly 48 output bits equal to the three words in order; nothing is lost or repeated.
- **Reset mid-word.**
  - Stimulus: assert RESET at beat 5 of 16'hFFFF with 16'h1234 sitting in the hold stage.
  - Required: outputs 0 the next cycle and PAR_READY=0 during reset.
  - Required: after release, the next accepted word 16'hC5AF streams correctly, with no trace of 16'h1234.
